// File: rtl/group_add_tree.sv
// group_add_tree: pipelined signed adder tree that reduces GROUP_NB packed
// NUM_WIDTH-bit operands to one saturated NUM_WIDTH-bit sum per clock.
// Internal nodes carry DEPTH guard bits, so no sum can wrap inside the tree.
// The final pairwise add is saturated and lands directly in the output
// register, so the latency is exactly DEPTH clock edges.
module group_add_tree #(
  parameter int GROUP_NB  = 4,
  parameter int NUM_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
  output logic [NUM_WIDTH-1:0]          dn_data
);

  // A single operand still gets one register stage, so the depth is at least 1.
  localparam int DEPTH = (GROUP_NB <= 1) ? 1 : $clog2(GROUP_NB);
  // Each level adds at most one bit of growth, so DEPTH guard bits cover the whole tree.
  localparam int SUM_W = NUM_WIDTH + DEPTH;

  localparam logic signed [NUM_WIDTH-1:0] MAX_NUM = {1'b0, {(NUM_WIDTH-1){1'b1}}};
  localparam logic signed [NUM_WIDTH-1:0] MIN_NUM = {1'b1, {(NUM_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0]     MAX_V   = SUM_W'(MAX_NUM);
  localparam logic signed [SUM_W-1:0]     MIN_V   = SUM_W'(MIN_NUM);

  // Number of entries present at tree level k (level 0 holds the raw operands).
  function automatic int level_cnt(input int k);
    return (GROUP_NB + (1 << k) - 1) >> k;
  endfunction

  // Levels 0 .. DEPTH-1 are built here.
  // The last add happens in the output stage below.
  for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
    localparam int N = level_cnt(k);
    logic signed [SUM_W-1:0] node [N];

    if (k == 0) begin : g_in
      // Sign-extend each packed operand to the internal width.
      for (genvar j = 0; j < N; j++) begin : g_ext
        assign node[j] = SUM_W'($signed(up_data[j*NUM_WIDTH +: NUM_WIDTH]));
      end
    end else begin : g_reg
      localparam int NP = level_cnt(k - 1);
      logic signed [SUM_W-1:0] node_d [N];
      logic signed [SUM_W-1:0] node_q [N];

      // Pair neighbours from the previous level.
      // An odd trailing entry is passed through unchanged.
      for (genvar j = 0; j < N; j++) begin : g_node
        if (2*j + 1 < NP) begin : g_pair
          assign node_d[j] = g_lvl[k-1].node[2*j] + g_lvl[k-1].node[2*j+1];
        end else begin : g_pass
          assign node_d[j] = g_lvl[k-1].node[2*j];
        end
      end

      // Register this tree level; reset clears any vectors in flight.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < N; j++) node_q[j] <= '0;
        end else begin
          for (int j = 0; j < N; j++) node_q[j] <= node_d[j];
        end
      end

      assign node = node_q;
    end
  end

  // The last built level always has one or two entries left to combine.
  localparam int NL = level_cnt(DEPTH - 1);

  logic signed [SUM_W-1:0]     final_sum;
  logic        [NUM_WIDTH-1:0] dn_d;
  logic        [NUM_WIDTH-1:0] dn_q;

  if (NL >= 2) begin : g_last_pair
    assign final_sum = g_lvl[DEPTH-1].node[0] + g_lvl[DEPTH-1].node[1];
  end else begin : g_last_pass
    assign final_sum = g_lvl[DEPTH-1].node[0];
  end

  // Clamp the full-precision sum into the NUM_WIDTH signed range.
  always_comb begin
    dn_d = final_sum[NUM_WIDTH-1:0];
    if (final_sum > MAX_V) begin
      dn_d = MAX_NUM;
    end else if (final_sum < MIN_V) begin
      dn_d = MIN_NUM;
    end
  end

  // The output register doubles as the last tree level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_q <= '0;
    end else begin
      dn_q <= dn_d;
    end
  end

  assign dn_data = dn_q;

endmodule

// File: tb/tb_group_add_tree.sv
// tb_group_add_tree: directed self-checking bench for group_add_tree.
// Three instances are exercised side by side:
//   - GROUP_NB=4 covers the main tree, signs, saturation and reset.
//   - GROUP_NB=3 covers the odd pass-through path.
//   - GROUP_NB=1 covers the single-register case.
module tb_group_add_tree;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] up4;
  logic [47:0] up3;
  logic [15:0] up1;
  logic [15:0] dn4;
  logic [15:0] dn3;
  logic [15:0] dn1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  group_add_tree #(.GROUP_NB(4), .NUM_WIDTH(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .up_data(up4), .dn_data(dn4)
  );
  group_add_tree #(.GROUP_NB(3), .NUM_WIDTH(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .up_data(up3), .dn_data(dn3)
  );
  group_add_tree #(.GROUP_NB(1), .NUM_WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .up_data(up1), .dn_data(dn1)
  );

  function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
    return {a, b, c, d};
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    up4 = pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    up3 = {16'h0101, 16'h0202, 16'h0303};
    up1 = 16'h5555;
    repeat (3) step();
    total++; if (dn4 !== 16'h0000) begin bad++; $display("[TB] FAIL reset_dn4: got %h want 0000", dn4); end
    total++; if (dn3 !== 16'h0000) begin bad++; $display("[TB] FAIL reset_dn3: got %h want 0000", dn3); end
    total++; if (dn1 !== 16'h0000) begin bad++; $display("[TB] FAIL reset_dn1: got %h want 0000", dn1); end
    #2;
    rst_n = 1'b1;
    up4 = '0;
    up3 = '0;
    up1 = '0;
    repeat (3) step();
    total++; if (dn4 !== 16'h0000) begin bad++; $display("[TB] FAIL idle_dn4: got %h want 0000", dn4); end
    total++; if (dn3 !== 16'h0000) begin bad++; $display("[TB] FAIL idle_dn3: got %h want 0000", dn3); end
    total++; if (dn1 !== 16'h0000) begin bad++; $display("[TB] FAIL idle_dn1: got %h want 0000", dn1); end
  endtask

  task automatic test_stream();
    logic [63:0] vec [5];
    logic [15:0] expv [6];
    vec[0] = pack4(16'h0400, 16'h0300, 16'h0200, 16'h0100);
    vec[1] = pack4(16'h0800, 16'h0700, 16'h0600, 16'h0500);
    vec[2] = pack4(16'h0C00, 16'h0B00, 16'h0A00, 16'h0900);
    vec[3] = pack4(16'h1000, 16'h0F00, 16'h0E00, 16'h0D00);
    vec[4] = pack4(16'h1400, 16'h1300, 16'h1200, 16'h1100);
    expv[0] = 16'h0A00;
    expv[1] = 16'h1A00;
    expv[2] = 16'h2A00;
    expv[3] = 16'h3A00;
    expv[4] = 16'h4A00;
    expv[5] = 16'h0000;
    up4 = vec[0];
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) begin
        total++; if (dn4 !== 16'h0000) begin bad++; $display("[TB] FAIL stream_early: got %h want 0000", dn4); end
      end else begin
        total++;
        if (dn4 !== expv[c-2]) begin
          bad++;
          $display("[TB] FAIL stream[%0d]: got %h want %h", c - 2, dn4, expv[c-2]);
        end
      end
      up4 = (c < 5) ? vec[c] : 64'h0;
    end
  endtask

  task automatic test_mixed_signs();
    up4 = pack4(16'h0080, 16'h0040, 16'hFDC0, 16'h0180);
    step();
    up4 = pack4(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
    step();
    total++; if (dn4 !== 16'h0000) begin bad++; $display("[TB] FAIL mixed_zero: got %h want 0000", dn4); end
    up4 = '0;
    step();
    total++; if (dn4 !== 16'hFC00) begin bad++; $display("[TB] FAIL mixed_neg4: got %h want fc00", dn4); end
    step();
  endtask

  task automatic test_saturation();
    up4 = pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    step();
    up4 = pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    step();
    total++; if (dn4 !== 16'h7FFF) begin bad++; $display("[TB] FAIL sat_pos: got %h want 7fff", dn4); end
    up4 = pack4(16'h7FFF, 16'h0001, 16'h0000, 16'h0000);
    step();
    total++; if (dn4 !== 16'h8000) begin bad++; $display("[TB] FAIL sat_neg: got %h want 8000", dn4); end
    up4 = '0;
    step();
    total++; if (dn4 !== 16'h7FFF) begin bad++; $display("[TB] FAIL sat_edge: got %h want 7fff", dn4); end
    step();
  endtask

  task automatic test_reset_midstream();
    up4 = pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    up1 = 16'h0777;
    step();
    up4 = pack4(16'h0200, 16'h0200, 16'h0200, 16'h0200);
    step();
    up4 = pack4(16'h0300, 16'h0300, 16'h0300, 16'h0300);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (dn4 !== 16'h0000) begin bad++; $display("[TB] FAIL async_rst_dn4: got %h want 0000", dn4); end
    total++; if (dn1 !== 16'h0000) begin bad++; $display("[TB] FAIL async_rst_dn1: got %h want 0000", dn1); end
    step();
    step();
    total++; if (dn4 !== 16'h0000) begin bad++; $display("[TB] FAIL rst_hold: got %h want 0000", dn4); end
    #3;
    rst_n = 1'b1;
    up4 = pack4(16'h0500, 16'h0100, 16'h0100, 16'h0100);
    up1 = '0;
    step();
    total++; if (dn4 !== 16'h0000) begin bad++; $display("[TB] FAIL post_rst_stale: got %h want 0000", dn4); end
    up4 = '0;
    step();
    total++; if (dn4 !== 16'h0800) begin bad++; $display("[TB] FAIL post_rst_first: got %h want 0800", dn4); end
    step();
    total++; if (dn4 !== 16'h0000) begin bad++; $display("[TB] FAIL post_rst_drain: got %h want 0000", dn4); end
  endtask

  task automatic test_non_pow2();
    up3 = '0;
    up1 = '0;
    repeat (3) step();
    up3 = {16'h0300, 16'h0200, 16'h0100};
    up1 = 16'h1234;
    step();
    total++; if (dn1 !== 16'h1234) begin bad++; $display("[TB] FAIL g1_first: got %h want 1234", dn1); end
    total++; if (dn3 !== 16'h0000) begin bad++; $display("[TB] FAIL g3_early: got %h want 0000", dn3); end
    up3 = {16'hFF00, 16'hFF00, 16'hFF00};
    up1 = 16'h8000;
    step();
    total++; if (dn3 !== 16'h0600) begin bad++; $display("[TB] FAIL g3_sum: got %h want 0600", dn3); end
    total++; if (dn1 !== 16'h8000) begin bad++; $display("[TB] FAIL g1_neg: got %h want 8000", dn1); end
    up3 = '0;
    up1 = '0;
    step();
    total++; if (dn3 !== 16'hFD00) begin bad++; $display("[TB] FAIL g3_neg: got %h want fd00", dn3); end
    total++; if (dn1 !== 16'h0000) begin bad++; $display("[TB] FAIL g1_zero: got %h want 0000", dn1); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_stream();
    test_mixed_signs();
    test_saturation();
    test_reset_midstream();
    test_non_pow2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/group_add_tree.md
Name: group_add_tree

Overview:
- Pipelined signed fixed-point adder tree; reduces GROUP_NB packed NUM_WIDTH-bit operands to one NUM_WIDTH-bit sum every clock.
- Sits downstream of the per-lane multiplier group in the convolution datapath and combines the lane partial products into one result.
- Streaming: no handshake. One new input vector is accepted and one result is produced per cycle.

Parameters:
- GROUP_NB, 4: number of operands summed; must be >= 1; need not be a power of two.
- NUM_WIDTH, 16: operand and result width in bits. Values are signed two's complement fixed point. The binary point position is irrelevant to the block.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- up_data, input, NUM_WIDTH*GROUP_NB: packed operands. Operand i is up_data[i*NUM_WIDTH +: NUM_WIDTH], signed.
- dn_data, output, NUM_WIDTH: signed, saturated sum of the operands, registered.

Behaviour:
- Binary tree of depth D = ceil(log2(GROUP_NB)). When GROUP_NB = 1, D is taken as 1 and that single stage is a plain register.
- Every tree level is registered, so latency = D clock edges from up_data being sampled to dn_data updating. Example: GROUP_NB=4 gives D=2.
- Level k pairs adjacent entries (0+1, 2+3, ...). An unpaired last entry at an odd count is passed through that level's register unchanged, keeping all paths aligned.
- Internal precision: operands are sign-extended and each level's sums are one bit wider than that level's inputs, so there is no overflow inside the tree.
- The final level's full-precision sum is saturated to NUM_WIDTH before the output register:
  - above 2^(NUM_WIDTH-1)-1 → 0x7FFF (for 16-bit);
  - below -2^(NUM_WIDTH-1) → 0x8000.
- Throughput: one result per cycle, fully pipelined. No stall and no enable.
- Reset (rst_n low): all pipeline registers and dn_data clear to 0 asynchronously. They stay 0 while rst_n is low.
- After rst_n deasserts, the first D outputs reflect whatever up_data was sampled after release. Vectors in flight during reset are discarded.
- Reset released mid-stream: output is 0 until the pipeline refills. No stale pre-reset sums ever appear.
- Arithmetic is purely integer. Fixed-point scaling is preserved because all operands share the same binary point.

Test Plan:
- Sequence with GROUP_NB=4, NUM_WIDTH=16, Q8.8 operands, one vector per cycle. Required dn_data values, appearing back-to-back exactly 2 cycles after their inputs:
  - {4,3,2,1} (0x0400,0x0300,0x0200,0x0100) → 10.0 = 0x0A00
  - {8,7,6,5} → 26.0 = 0x1A00
  - {12,11,10,9} → 42.0 = 0x2A00
  - {16,15,14,13} → 58.0 = 0x3A00
  - {20,19,18,17} → 74.0 = 0x4A00
  - then up_data=0 → 0x0000
- Mixed signs: {0.5, 0.25, -2.25, 1.5} (0x0080, 0x0040, 0xFDC0, 0x0180) → 0x0000. Then {-1,-1,-1,-1} → 0xFC00.
- Saturation: all operands 0x7FFF → 0x7FFF; all operands 0x8000 → 0x8000; {0x7FFF, 0x0001, 0, 0} → 0x7FFF.
- Reset: assert rst_n low asynchronously (between clock edges) while streaming.
  - dn_data goes to 0x0000 immediately.
  - After release, first nonzero output appears exactly 2 cycles after the first post-reset vector.
- Non-power-of-two, GROUP_NB=3: {1,2,3} (Q8.8) → 0x0600 after 2 cycles. GROUP_NB=1: operand 0x1234 → 0x1234 after 1 cycle.
